// File: rtl/mem_stage_ctrl.sv
// rtl/mem_stage_ctrl.sv - MEM-stage data-cache access controller
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   valid_in, is_load,       EX/MEM instruction qualifiers
//   is_store, funct3
//   addr, store_data         effective byte address and rs2 value
//   dmem_resp, dmem_rdata    d-cache completion and read word
//   dmem_read, dmem_write,   d-cache request, driven only from values
//   dmem_address,            captured when the access is accepted
//   dmem_wdata,
//   dmem_byte_enable
//   load_data                formatted result of the most recent load
//   mem_stall                holds the pipeline while an access is in flight
//   mem_fault                misaligned or illegal-width memory operation

module mem_stage_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_in,
    input  logic        is_load,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    input  logic        dmem_resp,
    input  logic [31:0] dmem_rdata,
    output logic        dmem_read,
    output logic        dmem_write,
    output logic [31:0] dmem_address,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_byte_enable,
    output logic [31:0] load_data,
    output logic        mem_stall,
    output logic        mem_fault
);

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t      state, state_next;

    logic        memop;
    logic        fault;
    logic [3:0]  be_calc;
    logic [31:0] wdata_calc;

    // Request captured at acceptance; the pipeline inputs may change freely
    // afterwards without disturbing the bus.
    logic [31:0] req_addr;
    logic        req_load;
    logic [3:0]  req_be;
    logic [31:0] req_wdata;
    logic [2:0]  req_funct3;
    logic [1:0]  req_off;

    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] load_fmt;

    assign memop = valid_in & (is_load | is_store);

    // Lane mask, replicated store data and alignment check from the width code.
    always_comb begin
        be_calc    = 4'b0000;
        wdata_calc = store_data;
        fault      = 1'b1;
        case (funct3)
            F3_B, F3_BU: begin
                be_calc    = 4'b0001 << addr[1:0];
                wdata_calc = {4{store_data[7:0]}};
                fault      = 1'b0;
            end
            F3_H, F3_HU: begin
                be_calc    = 4'b0011 << {addr[1], 1'b0};
                wdata_calc = {2{store_data[15:0]}};
                fault      = addr[0];
            end
            F3_W: begin
                be_calc    = 4'b1111;
                wdata_calc = store_data;
                fault      = (addr[1:0] != 2'b00);
            end
            default: begin
                be_calc    = 4'b0000;
                wdata_calc = store_data;
                fault      = 1'b1;
            end
        endcase
    end

    // Load formatting uses the captured offset/width, not the live inputs.
    always_comb begin
        rd_byte = 8'h00;
        case (req_off)
            2'd0: rd_byte = dmem_rdata[7:0];
            2'd1: rd_byte = dmem_rdata[15:8];
            2'd2: rd_byte = dmem_rdata[23:16];
            2'd3: rd_byte = dmem_rdata[31:24];
            default: rd_byte = dmem_rdata[7:0];
        endcase
        rd_half = req_off[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (req_funct3)
            F3_B:    load_fmt = {{24{rd_byte[7]}}, rd_byte};
            F3_H:    load_fmt = {{16{rd_half[15]}}, rd_half};
            F3_BU:   load_fmt = {24'h000000, rd_byte};
            F3_HU:   load_fmt = {16'h0000, rd_half};
            default: load_fmt = dmem_rdata;
        endcase
    end

    always_comb begin
        state_next = state;
        mem_stall  = 1'b0;
        mem_fault  = 1'b0;
        dmem_read  = 1'b0;
        dmem_write = 1'b0;
        case (state)
            IDLE: begin
                if (memop && fault) begin
                    mem_fault = 1'b1;
                end else if (memop) begin
                    mem_stall  = 1'b1;
                    state_next = ACCESS;
                end
            end
            ACCESS: begin
                mem_stall  = 1'b1;
                dmem_read  = req_load;
                dmem_write = ~req_load;
                if (dmem_resp) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                // Stall released: the pipeline advances on this edge.
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            req_addr   <= 32'h0;
            req_load   <= 1'b0;
            req_be     <= 4'h0;
            req_wdata  <= 32'h0;
            req_funct3 <= 3'b000;
            req_off    <= 2'b00;
            load_data  <= 32'h0;
        end else begin
            state <= state_next;
            if (state == IDLE && state_next == ACCESS) begin
                req_addr   <= {addr[31:2], 2'b00};
                req_load   <= is_load;
                req_be     <= be_calc;
                req_wdata  <= wdata_calc;
                req_funct3 <= funct3;
                req_off    <= addr[1:0];
            end
            if (state == ACCESS && dmem_resp && req_load) begin
                load_data <= load_fmt;
            end
        end
    end

    assign dmem_address     = req_addr;
    assign dmem_byte_enable = req_be;
    assign dmem_wdata       = req_wdata;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// tb/tb_mem_stage_ctrl.sv - randomized self-checking bench for mem_stage_ctrl

module tb_mem_stage_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid_in = 1'b0;
    logic        is_load = 1'b0;
    logic        is_store = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] addr = 32'h0;
    logic [31:0] store_data = 32'h0;
    logic        dmem_resp = 1'b0;
    logic [31:0] dmem_rdata = 32'h0;
    logic        dmem_read, dmem_write, mem_stall, mem_fault;
    logic [31:0] dmem_address, dmem_wdata, load_data;
    logic [3:0]  dmem_byte_enable;

    always #5 clk = ~clk;

    mem_stage_ctrl dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .is_load(is_load),
        .is_store(is_store), .funct3(funct3), .addr(addr),
        .store_data(store_data), .dmem_resp(dmem_resp), .dmem_rdata(dmem_rdata),
        .dmem_read(dmem_read), .dmem_write(dmem_write),
        .dmem_address(dmem_address), .dmem_wdata(dmem_wdata),
        .dmem_byte_enable(dmem_byte_enable), .load_data(load_data),
        .mem_stall(mem_stall), .mem_fault(mem_fault)
    );

    int checks = 0;
    int errors = 0;

    // Expected outputs for the current cycle, set by the driver.
    logic        chk_en = 1'b0;
    logic        e_read = 0, e_write = 0, e_stall = 0, e_fault = 0;
    logic        e_bus = 0, e_wd = 0;
    logic [31:0] e_addr = 0, e_wdata = 0, e_load = 0;
    logic [3:0]  e_be = 0;
    logic [31:0] model_load = 0;

    int          stall_cycles = 0, read_cycles = 0, write_cycles = 0, fault_cycles = 0;
    logic [31:0] seen_addr = 0, seen_wdata = 0;
    logic [3:0]  seen_be = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("dmem_read", {31'b0, dmem_read}, {31'b0, e_read});
            check("dmem_write", {31'b0, dmem_write}, {31'b0, e_write});
            check("mem_stall", {31'b0, mem_stall}, {31'b0, e_stall});
            check("mem_fault", {31'b0, mem_fault}, {31'b0, e_fault});
            check("load_data", load_data, e_load);
            if (e_bus) begin
                check("dmem_address", dmem_address, e_addr);
                check("dmem_byte_enable", {28'b0, dmem_byte_enable}, {28'b0, e_be});
            end
            if (e_wd) check("dmem_wdata", dmem_wdata, e_wdata);
            if (mem_stall) stall_cycles++;
            if (mem_fault) fault_cycles++;
            if (dmem_read) read_cycles++;
            if (dmem_write) write_cycles++;
            if (dmem_read || dmem_write) begin
                seen_addr  = dmem_address;
                seen_be    = dmem_byte_enable;
                seen_wdata = dmem_wdata;
            end
        end
    end

    // Reference rules written as plain arithmetic on the width code.
    function automatic logic m_fault(input logic [2:0] f3, input logic [31:0] a);
        int off;
        off = int'(a % 4);
        case (f3)
            3'd0, 3'd4: return 1'b0;
            3'd1, 3'd5: return (off % 2) != 0;
            3'd2:       return off != 0;
            default:    return 1'b1;
        endcase
    endfunction

    function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
        int off;
        off = int'(a % 4);
        case (f3)
            3'd0, 3'd4: return 4'(1 << off);
            3'd1, 3'd5: return 4'(3 << (off / 2 * 2));
            default:    return 4'd15;
        endcase
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] sd);
        case (f3)
            3'd0, 3'd4: return (sd % 256) * 32'h01010101;
            3'd1, 3'd5: return (sd % 65536) * 32'h00010001;
            default:    return sd;
        endcase
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd);
        logic [31:0] b, h;
        int off;
        off = int'(a % 4);
        b = (rd >> (8 * off)) % 256;
        h = (rd >> (8 * (off / 2 * 2))) % 65536;
        case (f3)
            3'd0:    return (b >= 128) ? b + 32'hFFFFFF00 : b;
            3'd1:    return (h >= 32768) ? h + 32'hFFFF0000 : h;
            3'd4:    return b;
            3'd5:    return h;
            default: return rd;
        endcase
    endfunction

    task automatic scramble_inputs();
        int r;
        r = $urandom_range(0, 2);
        valid_in   = 1'($urandom);
        is_load    = (r == 1);
        is_store   = (r == 2);
        funct3     = 3'($urandom);
        addr       = $urandom;
        store_data = $urandom;
    endtask

    task automatic do_op(input logic v, input logic ld, input logic st, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] sd, input int delay,
                         input logic [31:0] rd, input int rst_at);
        logic memop, flt;
        memop = v & (ld | st);
        flt   = memop & m_fault(f3, a);
        valid_in = v; is_load = ld; is_store = st; funct3 = f3; addr = a; store_data = sd;
        dmem_resp = 1'($urandom); dmem_rdata = $urandom;
        e_read = 0; e_write = 0; e_stall = memop & ~flt; e_fault = flt;
        e_bus = 0; e_wd = 0; e_load = model_load;
        @(posedge clk); #1;
        if (!memop || flt) return;
        for (int k = 1; k <= delay; k++) begin
            scramble_inputs();
            rst        = (k == rst_at);
            dmem_resp  = (k == delay);
            dmem_rdata = (k == delay) ? rd : $urandom;
            e_read = ld; e_write = st; e_stall = 1; e_fault = 0;
            e_bus = 1; e_addr = a & 32'hFFFFFFFC; e_be = m_be(f3, a);
            e_wd = st; e_wdata = m_wdata(f3, sd); e_load = model_load;
            @(posedge clk); #1;
            if (k == rst_at) begin
                rst = 0; valid_in = 0; dmem_resp = 1; dmem_rdata = rd;
                model_load = 0;
                e_read = 0; e_write = 0; e_stall = 0; e_fault = 0;
                e_bus = 1; e_addr = 0; e_be = 0; e_wd = 1; e_wdata = 0; e_load = 0;
                @(posedge clk); #1;
                return;
            end
        end
        if (ld) model_load = m_load(f3, a, rd);
        scramble_inputs();
        dmem_resp = 1'($urandom); dmem_rdata = $urandom;
        e_read = 0; e_write = 0; e_stall = 0; e_fault = 0;
        e_bus = 0; e_wd = 0; e_load = model_load;
        @(posedge clk); #1;
    endtask

    task automatic idle_cycle();
        do_op(1'b0, 1'b0, 1'b0, 3'b000, $urandom, $urandom, 1, 32'h0, 0);
    endtask

    initial begin
        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        rst = 0; valid_in = 0; dmem_resp = 1; model_load = 0;
        e_read = 0; e_write = 0; e_stall = 0; e_fault = 0;
        e_bus = 1; e_addr = 0; e_be = 0; e_wd = 1; e_wdata = 0; e_load = 0;
        chk_en = 1;
        @(posedge clk); #1;
        idle_cycle();

        // LB with response on the second ACCESS cycle
        stall_cycles = 0;
        do_op(1, 1, 0, 3'b000, 32'h1003, 32'h0, 2, 32'h80FFFFFF, 0);
        check("lb_load_data", load_data, 32'hFFFFFF80);
        check("lb_stall_cycles", stall_cycles, 3);
        check("lb_address", seen_addr, 32'h00001000);
        check("lb_byte_enable", {28'b0, seen_be}, 32'h8);

        // SH to upper half
        write_cycles = 0;
        do_op(1, 0, 1, 3'b001, 32'h2002, 32'h0000BEEF, 1, 32'h0, 0);
        check("sh_write_cycles", write_cycles, 1);
        check("sh_byte_enable", {28'b0, seen_be}, 32'hC);
        check("sh_wdata", seen_wdata, 32'hBEEFBEEF);
        check("sh_load_unchanged", load_data, 32'hFFFFFF80);

        // Misaligned LW faults without a request, then LHU
        read_cycles = 0; stall_cycles = 0; fault_cycles = 0;
        do_op(1, 1, 0, 3'b010, 32'h3001, 32'h0, 1, 32'h0, 0);
        check("lw_fault_cycles", fault_cycles, 1);
        check("lw_fault_reads", read_cycles, 0);
        check("lw_fault_stall", stall_cycles, 0);
        do_op(1, 1, 0, 3'b101, 32'h3002, 32'h0, 1, 32'h8001ABCD, 0);
        check("lhu_load_data", load_data, 32'h00008001);

        // Reset during the second ACCESS cycle, late response ignored
        do_op(1, 1, 0, 3'b010, 32'h40, 32'h0, 5, 32'h12345678, 2);
        dmem_resp = 1;
        idle_cycle();
        check("rst_load_data", load_data, 32'h0);

        // Back-to-back LW then SW with immediate responses
        stall_cycles = 0; read_cycles = 0; write_cycles = 0;
        do_op(1, 1, 0, 3'b010, 32'h10, 32'h0, 1, 32'hCAFEF00D, 0);
        check("b2b_lw_address", seen_addr, 32'h10);
        do_op(1, 0, 1, 3'b010, 32'h14, 32'h11223344, 1, 32'h0, 0);
        check("b2b_sw_address", seen_addr, 32'h14);
        check("b2b_sw_wdata", seen_wdata, 32'h11223344);
        check("b2b_stall_cycles", stall_cycles, 4);
        check("b2b_read_cycles", read_cycles, 1);
        check("b2b_write_cycles", write_cycles, 1);
        check("b2b_load_data", load_data, 32'hCAFEF00D);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            int kind, dly, ra;
            logic [2:0] f3;
            kind = $urandom_range(0, 9);
            f3   = ($urandom_range(0, 7) == 0) ? 3'($urandom) : 3'(($urandom_range(0, 4) == 3) ? 2 : $urandom_range(0, 5));
            if (f3 == 3'd3) f3 = 3'd4;
            if ($urandom_range(0, 9) == 0) f3 = 3'($urandom);
            dly  = $urandom_range(1, 4);
            ra   = ($urandom_range(0, 19) == 0 && dly > 1) ? $urandom_range(1, dly - 1) : 0;
            do_op((kind != 0), (kind >= 1 && kind <= 5), (kind >= 6), f3,
                  $urandom, $urandom, dly, $urandom, ra);
        end

        chk_en = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_stage_ctrl.md
MEM_STAGE_CTRL -- requirements
Module: mem_stage_ctrl

Interface
REQ-001 SHALL have port clk  input  1  pipeline clock; all state updates on posedge clk.
REQ-002 SHALL have port rst  input  1  reset; one clock, reset synchronous and active-high.
REQ-003 SHALL have port valid_in  input  1  EX/MEM register holds a valid instruction.
REQ-004 SHALL have port is_load  input  1  instruction is a load.
REQ-005 SHALL have port is_store  input  1  instruction is a store; never high together with is_load.
REQ-006 SHALL have port funct3  input  3  width code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-007 SHALL have port addr  input  32  ALU effective byte address.
REQ-008 SHALL have port store_data  input  32  rs2 value.
REQ-009 SHALL have port dmem_resp  input  1  d-cache completes the current request.
REQ-010 SHALL have port dmem_rdata  input  32  d-cache read word, valid with dmem_resp.
REQ-011 SHALL have port dmem_read  output  1  d-cache read request.
REQ-012 SHALL have port dmem_write  output  1  d-cache write request.
REQ-013 SHALL have port dmem_address  output  32  word-aligned address ({addr[31:2],2'b00}).
REQ-014 SHALL have port dmem_wdata  output  32  lane-replicated store data.
REQ-015 SHALL have port dmem_byte_enable  output  4  byte-lane write mask.
REQ-016 SHALL have port load_data  output  32  formatted load result, fed to MEM/WB d-cache data input.
REQ-017 SHALL have port mem_stall  output  1  freezes PC and all pipeline registers when high.
REQ-018 SHALL have port mem_fault  output  1  misaligned or illegal-funct3 access detected.

Function
REQ-019 SHALL implement FSM states IDLE, ACCESS, DONE.
REQ-020 memop = valid_in & (is_load|is_store); fault = H/HU with addr[0]=1, W with addr[1:0]!=0, or funct3 outside listed codes.
REQ-021 IDLE: memop & !fault -> ACCESS, mem_stall=1 combinationally; otherwise stay IDLE, mem_stall=0.
REQ-022 IDLE with memop & fault: mem_fault=1 combinationally, no request issued, no stall, load_data unchanged.
REQ-023 On IDLE->ACCESS SHALL latch address, direction, byte_enable and wdata; dmem_* outputs driven from latched values only.
REQ-024 ACCESS: exactly one of dmem_read/dmem_write high, held with stable address/data until dmem_resp; mem_stall=1.
REQ-025 ACCESS with dmem_resp: load -> register formatted dmem_rdata into load_data; -> DONE; request deasserted next cycle.
REQ-026 DONE: mem_stall=0, request low, inputs ignored (pipeline advances at this edge); -> IDLE unconditionally.
REQ-027 Latency: request first visible 1 cycle after memop arrives; minimum occupancy 3 cycles (IDLE, ACCESS, DONE) when resp arrives in first ACCESS cycle.
REQ-028 Byte enable: B/BU 4'b0001<<addr[1:0]; H/HU 4'b0011<<{addr[1],1'b0}; W 4'b1111; loads also drive this mask.
REQ-029 wdata: B {4{store_data[7:0]}}, H {2{store_data[15:0]}}, W store_data.
REQ-030 Load format: select byte addr[1:0] / half addr[1]; B,H sign-extend; BU,HU zero-extend; W unchanged.
REQ-031 load_data SHALL hold its value until the next load completes; stores do not alter it.
REQ-032 dmem_resp in IDLE or DONE SHALL be ignored.

Reset
REQ-033 rst=1 at any state (incl. mid-ACCESS) SHALL force IDLE next edge; dmem_read/write=0, dmem_byte_enable=0, dmem_address=0, dmem_wdata=0, load_data=0.
REQ-034 After reset, mem_stall=0 and mem_fault=0 until a memop is presented.

Verification
REQ-035 LB addr=0x1003, rdata=0x80FFFFFF, resp on 2nd ACCESS cycle -> dmem_address=0x1000, BE=0001<<3, load_data=0xFFFFFF80, stall high 3 cycles.
REQ-036 SH addr=0x2002, store_data=0x0000BEEF -> dmem_write=1, BE=4'b1100, wdata=0xBEEFBEEF, load_data unchanged.
REQ-037 LW addr=0x3001 -> mem_fault=1, no dmem_read, mem_stall=0; LHU addr=0x3002 rdata=0x8001xxxx -> load_data=0x00008001.
REQ-038 LW issued, rst asserted 2nd ACCESS cycle, resp arrives after -> IDLE, read drops next edge, load_data=0, late resp ignored.
REQ-039 Back-to-back LW 0x10 then SW 0x14, resp immediate -> each 3-cycle occupancy, no overlap of read/write, address stable while requested.
